// File: rtl/bind_stream_checker.sv
// Valid/ready protocol checker meant to be bound into a target module.
// One bind_stream_checker_ch per channel tracks pending state, held data,
// stall length and a saturating transfer count. The top ORs the per-channel
// next-state error bits into err_any and latches the first offending channel.

module bind_stream_checker_ch #(
    parameter int DW        = 8,
    parameter int CNTW      = 16,
    parameter int MAX_STALL = 15,
    parameter int SW        = $clog2(MAX_STALL + 2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            valid,
    input  logic            ready,
    input  logic [DW-1:0]   data,
    output logic [CNTW-1:0] cnt,
    output logic            err_hold,
    output logic            err_drop,
    output logic            err_stall,
    output logic            err_nxt
);
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} st_t;

    localparam logic [SW-1:0] STALL_LIM = SW'(MAX_STALL);
    localparam logic [SW-1:0] STALL_SAT = SW'(MAX_STALL + 1);

    st_t            st;
    logic [DW-1:0]  held;
    logic [SW-1:0]  stall_cnt;

    logic stall_ev, xfer_ev, hold_ev, drop_ev, stall_err_ev;
    logic hold_n, drop_n, stall_n;

    // Per-edge violation events and the sticky values they lead to
    always_comb begin
        stall_ev     = valid & ~ready;
        xfer_ev      = valid & ready;
        hold_ev      = (st == PEND) & valid & (data != held);
        drop_ev      = (st == PEND) & ~valid;
        // only the edge that reaches MAX_STALL+1 fires; saturation stops repeats
        stall_err_ev = stall_ev & (stall_cnt == STALL_LIM);
        hold_n       = err_hold  | hold_ev;
        drop_n       = err_drop  | drop_ev;
        stall_n      = err_stall | stall_err_ev;
        err_nxt      = hold_n | drop_n | stall_n;
    end

    // Channel state, held data, stall counter, transfer count, sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            held      <= '0;
            stall_cnt <= '0;
            cnt       <= '0;
            err_hold  <= 1'b0;
            err_drop  <= 1'b0;
            err_stall <= 1'b0;
        end else if (clr) begin
            st        <= IDLE;
            held      <= '0;
            stall_cnt <= '0;
            cnt       <= '0;
            err_hold  <= 1'b0;
            err_drop  <= 1'b0;
            err_stall <= 1'b0;
        end else begin
            case (st)
                IDLE: if (stall_ev) begin
                    st   <= PEND;
                    held <= data;
                end
                PEND: if (!valid || ready) st <= IDLE;
                default: st <= IDLE;
            endcase
            if (!stall_ev)                    stall_cnt <= '0;
            else if (stall_cnt != STALL_SAT)  stall_cnt <= stall_cnt + 1'b1;
            if (xfer_ev && cnt != '1)         cnt <= cnt + 1'b1;
            err_hold  <= hold_n;
            err_drop  <= drop_n;
            err_stall <= stall_n;
        end
    end
endmodule

module bind_stream_checker #(
    parameter int NCH       = 2,
    parameter int DW        = 8,
    parameter int CNTW      = 16,
    parameter int MAX_STALL = 15,
    parameter int IW        = (NCH > 1 ? $clog2(NCH) : 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [NCH-1:0]      valid,
    input  logic [NCH-1:0]      ready,
    input  logic [NCH*DW-1:0]   data,
    output logic [NCH*CNTW-1:0] xfer_cnt,
    output logic [NCH-1:0]      err_hold,
    output logic [NCH-1:0]      err_drop,
    output logic [NCH-1:0]      err_stall,
    output logic                err_any,
    output logic [IW-1:0]       first_err_ch
);
    logic [NCH-1:0][CNTW-1:0] cnt;
    logic [NCH-1:0]           err_nxt;
    logic [IW-1:0]            first_nxt;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        bind_stream_checker_ch #(
            .DW(DW), .CNTW(CNTW), .MAX_STALL(MAX_STALL)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .valid    (valid[g]),
            .ready    (ready[g]),
            .data     (data[g*DW +: DW]),
            .cnt      (cnt[g]),
            .err_hold (err_hold[g]),
            .err_drop (err_drop[g]),
            .err_stall(err_stall[g]),
            .err_nxt  (err_nxt[g])
        );
    end

    assign xfer_cnt = cnt;

    // Lowest-index channel with an error after this edge; when err_any is
    // still 0 every sticky bit is clear, so these are exactly the new errors
    always_comb begin
        first_nxt = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (err_nxt[i]) first_nxt = IW'(i);
    end

    // err_any tracks the error bits on the same edge; first channel latches once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_any      <= 1'b0;
            first_err_ch <= '0;
        end else if (clr) begin
            err_any      <= 1'b0;
            first_err_ch <= '0;
        end else begin
            err_any <= |err_nxt;
            if (!err_any && |err_nxt) first_err_ch <= first_nxt;
        end
    end
endmodule

// File: tb/tb_bind_stream_checker.sv
// Directed bench: a vector table for the basic transfer/error sequences and
// hand-written sequences for stall boundary, saturation and async reset.

module tb_bind_stream_checker;
    localparam int NCH = 2, DW = 8, CNTW = 4, MAX_STALL = 15, IW = 1;

    logic                clk = 1'b0;
    logic                rst_n, clr;
    logic [NCH-1:0]      valid, ready;
    logic [NCH*DW-1:0]   data;
    logic [NCH*CNTW-1:0] xfer_cnt;
    logic [NCH-1:0]      err_hold, err_drop, err_stall;
    logic                err_any;
    logic [IW-1:0]       first_err_ch;

    int errors = 0;
    int checks = 0;

    bind_stream_checker #(.NCH(NCH), .DW(DW), .CNTW(CNTW), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .valid(valid), .ready(ready), .data(data),
        .xfer_cnt(xfer_cnt), .err_hold(err_hold), .err_drop(err_drop), .err_stall(err_stall),
        .err_any(err_any), .first_err_ch(first_err_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] v, r;
        logic [7:0] d1, d0;
        logic       c;
        logic [3:0] c1, c0;
        logic [1:0] eh, ed, es;
        logic       ea, ef;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c1, input int c0, input int eh,
                           input int ed, input int es, input int ea, input int ef);
        chk({tag, " cnt1"},  int'(xfer_cnt[7:4]), c1);
        chk({tag, " cnt0"},  int'(xfer_cnt[3:0]), c0);
        chk({tag, " hold"},  int'(err_hold),      eh);
        chk({tag, " drop"},  int'(err_drop),      ed);
        chk({tag, " stall"}, int'(err_stall),     es);
        chk({tag, " any"},   int'(err_any),       ea);
        chk({tag, " first"}, int'(first_err_ch),  ef);
    endtask

    // Drive inputs mid-cycle, take one edge, settle to sample away from the edge
    task automatic step(input logic [1:0] v, input logic [1:0] r,
                        input logic [7:0] d1, input logic [7:0] d0, input logic c);
        valid = v; ready = r; data = {d1, d0}; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        string tag;
        // transfers, hold violation, clr
        for (int i = 0; i < 5; i++)
            tbl[i] = '{2'b01, 2'b01, 8'h00, 8'(i), 1'b0, 4'd0, 4'(i + 1), 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{2'b10, 2'b00, 8'h3C, 8'h00, 1'b0, 4'd0, 4'd5, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{2'b10, 2'b10, 8'h3D, 8'h00, 1'b0, 4'd1, 4'd5, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[7]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        // drop on ch0, then clr over a transfer
        tbl[8]  = '{2'b01, 2'b00, 8'h00, 8'hAA, 1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{2'b01, 2'b00, 8'h00, 8'hAA, 1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[10] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[11] = '{2'b01, 2'b01, 8'h00, 8'hAA, 1'b1, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[12] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        // simultaneous first errors: ch0 drop + ch1 hold; later ch1 drop
        tbl[13] = '{2'b11, 2'b00, 8'h22, 8'h11, 1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[14] = '{2'b10, 2'b00, 8'h23, 8'h00, 1'b0, 4'd0, 4'd0, 2'b10, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[15] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 4'd0, 4'd0, 2'b10, 2'b11, 2'b00, 1'b1, 1'b0};
        tbl[16] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

        rst_n = 1'b0; clr = 1'b0; valid = '0; ready = '0; data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].r, tbl[i].d1, tbl[i].d0, tbl[i].c);
            $sformat(tag, "vec%0d", i);
            chk_all(tag, tbl[i].c1, tbl[i].c0, tbl[i].eh, tbl[i].ed, tbl[i].es, tbl[i].ea, tbl[i].ef);
        end

        // stall boundary: ch0 stalls 15 then is accepted, ch1 stalls 16
        for (int k = 1; k <= 15; k++) begin
            step(2'b11, 2'b00, 8'h55, 8'h66, 1'b0);
            $sformat(tag, "stall%0d", k);
            chk({tag, " stall"}, int'(err_stall), 0);
        end
        step(2'b11, 2'b01, 8'h55, 8'h66, 1'b0);
        chk_all("stall16", 0, 1, 0, 0, 2, 1, 1);

        // counter saturation at 2^CNTW-1
        step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
        chk_all("clr2", 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step(2'b01, 2'b01, 8'h00, 8'(k), 1'b0);
            $sformat(tag, "sat%0d", k);
            chk({tag, " cnt0"}, int'(xfer_cnt[3:0]), (k > 15) ? 15 : k);
        end

        // async reset mid-cycle while ch1 is pending
        step(2'b10, 2'b00, 8'h77, 8'h00, 1'b0);
        chk("pre-rst cnt0", int'(xfer_cnt[3:0]), 15);
        rst_n = 1'b0;
        #2;
        chk_all("async rst", 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        // pend must have been cleared: differing data with ready is a clean transfer
        step(2'b10, 2'b10, 8'h78, 8'h00, 1'b0);
        chk_all("post-rst", 1, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
